// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path: opcodes, ALU
// operation classes (also consumed by the ALU control decoder) and the
// main control FSM state encoding.
package mips_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 3'b010;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ADDI_EXEC = 4'd11,
        S_ADDI_WB   = 4'd12
    } state_t;

    // True for every opcode the control FSM knows how to sequence.
    function automatic logic op_legal(input logic [OPCODE_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   run               level enable; leave IDLE / keep fetching while high
//   opcode            IR[31:26], valid from DECODE onward
//   mem_ready         memory completes the current access this cycle
//   pc_write .. pc_source  datapath control, decoded from the state
//   illegal_op        pulse in DECODE on an unsupported opcode
//   busy              high outside IDLE
//   retired           count of completed instructions (wraps)
//   state_out         current state encoding, for debug
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [5:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic                illegal_op,
    output logic                busy,
    output logic [RETIRE_W-1:0] retired,
    output logic [3:0]          state_out
);

    state_t state;
    state_t state_nxt;
    logic   retire_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Retired-instruction counter, bumped on the edge leaving a terminal state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + RETIRE_W'(1);
        end
    end

    // Next-state logic; terminal states pick FETCH or IDLE from run.
    always_comb begin
        state_nxt = state;
        retire_c  = 1'b0;
        unique case (state)
            S_IDLE:   if (run) state_nxt = S_FETCH;
            S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = S_R_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDI:      state_nxt = S_ADDI_EXEC;
                    default:      state_nxt = run ? S_FETCH : S_IDLE;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    if (mem_ready) state_nxt = S_MEM_WB;
            S_MEM_WR: begin
                if (mem_ready) begin
                    retire_c  = 1'b1;
                    state_nxt = run ? S_FETCH : S_IDLE;
                end
            end
            S_R_EXEC:    state_nxt = S_R_WB;
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: begin
                retire_c  = 1'b1;
                state_nxt = run ? S_FETCH : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode of the registered state; FETCH's IR/PC latch waits for mem_ready.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = ALUOP_ADD;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        busy          = (state != S_IDLE);
        unique case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = 2'b11;
                illegal_op = !op_legal(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            S_ADDI_WB: reg_write = 1'b1;
            default: ;
        endcase
    end

    assign state_out = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized instruction-stream bench for mips_multicycle_control. Each
// instruction is expanded into its expected per-cycle state path (with the
// bench's own choice of memory stalls and run level) and every cycle's
// outputs and retired count are checked against that path.
module tb_mips_multicycle_control;

    localparam int unsigned RW = 4;

    localparam logic [3:0] T_IDLE = 4'd0,  T_FETCH = 4'd1,  T_DECODE = 4'd2,
                           T_MADDR = 4'd3, T_MRD = 4'd4,    T_MWB = 4'd5,
                           T_MWR = 4'd6,   T_REX = 4'd7,    T_RWB = 4'd8,
                           T_BR = 4'd9,    T_JMP = 4'd10,   T_AEX = 4'd11,
                           T_AWB = 4'd12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic [5:0]    opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, busy;
    logic [1:0]    alu_src_b, pc_source;
    logic [2:0]    alu_op;
    logic [RW-1:0] retired;
    logic [3:0]    state_out;

    mips_multicycle_control #(.RETIRE_W(RW)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .busy(busy),
        .retired(retired), .state_out(state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
        logic       rn;
        logic       term;
    } step_t;

    step_t         q[$];
    int            total = 0;
    int            bad = 0;
    logic [RW-1:0] exp_ret = '0;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Expected control vector per state, straight from the behaviour table:
    // {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, busy}
    function automatic logic [18:0] exp_vec(input logic [3:0] st, input logic mr, input logic [5:0] op);
        logic pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            T_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pw = mr; end
            T_DECODE: begin sb = 2'b11; ill = !is_legal(op); end
            T_MADDR, T_AEX: begin sa = 1; sb = 2'b10; end
            T_MRD:    begin mrd = 1; io = 1; end
            T_MWB:    begin rw = 1; m2r = 1; end
            T_MWR:    begin mwr = 1; io = 1; end
            T_REX:    begin sa = 1; ao = 3'b010; end
            T_RWB:    begin rw = 1; rd = 1; end
            T_BR:     begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            T_JMP:    begin pw = 1; ps = 2'b10; end
            T_AWB:    rw = 1;
            default: ;
        endcase
        return {pw, pwc, io, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps, ill, st != T_IDLE};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] dut_vec();
        return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
                reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, busy};
    endfunction

    function automatic step_t mk(input logic [3:0] st, input logic mr, input logic rn, input logic term);
        step_t s;
        s.st = st; s.mr = mr; s.rn = rn; s.term = term;
        return s;
    endfunction

    // Expected path of one instruction from FETCH to its last state.
    task automatic build(input logic [5:0] op, input int kf, input int kr, input logic stop);
        logic rb;
        for (int i = 0; i < kf; i++) q.push_back(mk(T_FETCH, 1'b0, 1'($urandom), 1'b0));
        q.push_back(mk(T_FETCH, 1'b1, 1'($urandom), 1'b0));
        rb = is_legal(op) ? 1'($urandom) : !stop;
        q.push_back(mk(T_DECODE, 1'($urandom), rb, 1'b0));
        case (op)
            6'b000000: begin
                q.push_back(mk(T_REX, 1'($urandom), 1'($urandom), 1'b0));
                q.push_back(mk(T_RWB, 1'($urandom), !stop, 1'b1));
            end
            6'b100011: begin
                q.push_back(mk(T_MADDR, 1'($urandom), 1'($urandom), 1'b0));
                for (int i = 0; i < kr; i++) q.push_back(mk(T_MRD, 1'b0, 1'($urandom), 1'b0));
                q.push_back(mk(T_MRD, 1'b1, 1'($urandom), 1'b0));
                q.push_back(mk(T_MWB, 1'($urandom), !stop, 1'b1));
            end
            6'b101011: begin
                q.push_back(mk(T_MADDR, 1'($urandom), 1'($urandom), 1'b0));
                for (int i = 0; i < kr; i++) q.push_back(mk(T_MWR, 1'b0, 1'($urandom), 1'b0));
                q.push_back(mk(T_MWR, 1'b1, !stop, 1'b1));
            end
            6'b000100: q.push_back(mk(T_BR, 1'($urandom), !stop, 1'b1));
            6'b000010: q.push_back(mk(T_JMP, 1'($urandom), !stop, 1'b1));
            6'b001000: begin
                q.push_back(mk(T_AEX, 1'($urandom), 1'($urandom), 1'b0));
                q.push_back(mk(T_AWB, 1'($urandom), !stop, 1'b1));
            end
            default: ;
        endcase
        if (stop) begin
            q.push_back(mk(T_IDLE, 1'($urandom), 1'b0, 1'b0));
            q.push_back(mk(T_IDLE, 1'($urandom), 1'b1, 1'b0));
        end
    endtask

    // Drive and check every queued cycle; opcode is garbage until DECODE.
    task automatic play(input logic [5:0] op);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.mr;
            run       = s.rn;
            opcode    = (s.st == T_FETCH || s.st == T_IDLE) ? 6'($urandom) : op;
            #1;
            chk("state", 32'(state_out), 32'(s.st));
            chk("ctrl", 32'(dut_vec()), 32'(exp_vec(s.st, s.mr, opcode)));
            chk("retired", 32'(retired), 32'(exp_ret));
            if (s.term) exp_ret = exp_ret + RW'(1);
        end
    endtask

    task automatic instr(input logic [5:0] op, input int kf, input int kr, input logic stop);
        build(op, kf, kr, stop);
        play(op);
    endtask

    initial begin
        logic [5:0] ops [6];
        logic [5:0] op;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;

        // Reset with run held high: IDLE, everything zero.
        rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 6'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state_out), 32'(T_IDLE));
        chk("rst_ctrl", 32'(dut_vec()), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        rst_n = 1'b1;

        // Directed: R, lw with 3 stalls, beq, j, illegal, R dropping run.
        instr(6'b000000, 0, 0, 1'b0);
        instr(6'b100011, 0, 3, 1'b0);
        instr(6'b000100, 0, 0, 1'b0);
        instr(6'b000010, 0, 0, 1'b0);
        instr(6'b111111, 0, 0, 1'b0);
        instr(6'b000000, 1, 0, 1'b1);
        instr(6'b101011, 2, 2, 1'b0);
        instr(6'b001000, 0, 0, 1'b1);

        // Random stream; RW=4 makes retired wrap several times.
        for (int n = 0; n < 150; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
            instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of a stalled store aborts asynchronously.
        q.push_back(mk(T_FETCH, 1'b1, 1'b1, 1'b0));
        q.push_back(mk(T_DECODE, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(T_MADDR, 1'b0, 1'b1, 1'b0));
        q.push_back(mk(T_MWR, 1'b0, 1'b1, 1'b0));
        play(6'b101011);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'(T_IDLE));
        chk("arst_mem_write", 32'(mem_write), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_retired", 32'(retired), 32'd0);
        exp_ret = '0;
        @(negedge clk);
        mem_ready = 1'b1;
        rst_n = 1'b1;
        // No leftover write after release: next state is FETCH, then a clean R.
        instr(6'b000000, 0, 0, 1'b0);
        instr(6'b100011, 1, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Moore-style main control FSM for the multicycle MIPS datapath. Sequences fetch, decode, execute, memory and writeback for R-type, lw, sw, beq, j and addi. Drives the 3-bit ALU operation class into the ALU control decoder, where class 010 selects decoding by funct. Stalls on a memory ready handshake and counts retired instructions.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  level; leave IDLE and begin fetching while high
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
iord  out  1  0: PC addresses memory, 1: ALUOut addresses memory
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch instruction register
mem_to_reg  out  1  writeback source 1: MDR, 0: ALUOut
reg_dst  out  1  destination 1: rd, 0: rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0: PC, 1: register A
alu_src_b  out  2  00: B, 01: constant 4, 10: sign-extended imm, 11: imm<<2
alu_op  out  3  000 add, 001 sub, 010 decode by funct
pc_source  out  2  00: ALU result, 01: ALUOut, 10: jump target
illegal_op  out  1  one-cycle pulse on an unsupported opcode
busy  out  1  high in every state except IDLE
retired  out  RETIRE_W  count of completed instructions
state_out  out  4  current state encoding, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, retired 0. All decoded outputs 0 in IDLE, including alu_op 000, alu_src_b 00, pc_source 00, busy 0.
- Outputs are a pure decode of the registered state. Only transitions depend on inputs. No same-cycle input-to-output path.
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encodings: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, BRANCH 9, JUMP 10, ADDI_EXEC 11, ADDI_WB 12.
- IDLE: go to FETCH if run=1, otherwise stay in IDLE.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
  - ir_write=1 and pc_write=1 are asserted only in the cycle where mem_ready=1 (the single exception to pure state decode; these two are qualified by mem_ready).
  - Hold FETCH while mem_ready=0. On mem_ready=1 go to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=000 (branch target precompute).
  - Next state by opcode: lw/sw -> MEM_ADDR, R -> R_EXEC, beq -> BRANCH, j -> JUMP, addi -> ADDI_EXEC.
  - Any other opcode: illegal_op=1 this cycle, then go to FETCH if run=1, otherwise IDLE.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Go to MEM_RD if the opcode is lw, otherwise MEM_WR.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready=1, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready=1.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=010, then go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01.
- JUMP: pc_write=1, pc_source=10.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=000, then go to ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0.
- Terminal states are MEM_WB, MEM_WR (on mem_ready), R_WB, BRANCH, JUMP and ADDI_WB. From a terminal state:
  - retired increments by 1 on that clock edge.
  - Next state is FETCH if run=1, otherwise IDLE. An instruction in progress always completes even if run drops.
- Illegal opcodes do not increment retired. retired wraps from all-ones to 0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- Reset asserted mid-instruction aborts immediately to IDLE. No partial writeback is issued after reset release.

Decomposition:
- Shared package mips_pkg holds:
  - opcode localparams (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - ALU-class constants (ALUOP_ADD 000, ALUOP_SUB 001, ALUOP_FUNCT 010), shared with the ALU control decoder;
  - the state encoding constants.
- No sub-module. A single FSM with a next-state block and an output decode block is sufficient.

Test Plan:
- Reset with run=1 held -> in IDLE all outputs 0 and retired=0. After rst_n rises, FETCH on the next edge with mem_read=1, alu_src_b=01.
- R-type (opcode 000000), mem_ready=1 in FETCH -> FETCH, DECODE, R_EXEC (alu_op=010), R_WB (reg_write=1, reg_dst=1). Total 4 cycles, retired 0 to 1.
- lw with mem_ready held 0 for 3 cycles in MEM_RD -> state holds MEM_RD for 4 cycles, then MEM_WB with mem_to_reg=1. Instruction takes 8 cycles.
- beq -> BRANCH asserts alu_op=001, pc_write_cond=1, pc_source=01. j -> JUMP asserts pc_write=1, pc_source=10. Each retires in 3 cycles.
- Opcode 111111 -> illegal_op pulses for exactly 1 cycle in DECODE, retired unchanged, returns to FETCH.
- Drop run during R_EXEC -> R_WB completes, retired increments, then IDLE with busy=0. Assert rst_n low in MEM_WR -> IDLE asynchronously, mem_write drops to 0 before the next clock edge.
